// File: rtl/unpack_pkg.sv
// Shared definitions for the block packer/unpacker pair.
package unpack_pkg;

    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_WORDS = 4;

    // Unpacker states
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

endpackage

// File: rtl/word_counter.sv
// Word index counter that wraps to zero after the last word of a block.
module word_counter
    import unpack_pkg::*;
#(
    parameter int unsigned WORDS = DEF_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] idx_next_c,
    output logic              last_c
);

    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;

    assign last_c     = (idx_q == ADDR_W'(WORDS - 1));
    assign idx_next_c = idx_d;

    // Next index: clear on block start, advance or wrap on each transfer
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = last_c ? '0 : idx_q + ADDR_W'(1);
        end
    end

    // Index register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/block_unpacker.sv
// Streams a captured WORDS x WIDTH block out one word at a time, word 0 first.
module block_unpacker
    import unpack_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned WORDS = DEF_WORDS
) (
    input  logic                   Clock,
    input  logic                   Res,
    input  logic                   Load,
    input  logic [WORDS*WIDTH-1:0] In_block,
    output logic                   In_ready,
    output logic                   Out_valid,
    input  logic                   Out_ready,
    output logic [WIDTH-1:0]       Out_data,
    output logic [ADDR_W-1:0]      Addr_out,
    output logic                   Done
);

    logic [0:0]             state_q, state_d;
    logic [WORDS*WIDTH-1:0] buf_q, buf_d;
    logic                   done_q, done_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       out_data_q, out_data_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;

    logic                   cnt_clr;
    logic                   cnt_inc;
    logic [ADDR_W-1:0]      idx_next;
    logic                   idx_last;

    // Word k lives in the k-th slice counted from the MSB end
    function automatic logic [WIDTH-1:0] word_sel(input logic [WORDS*WIDTH-1:0] blk,
                                                  input logic [ADDR_W-1:0]      k);
        word_sel = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (k == ADDR_W'(i)) begin
                word_sel = blk[(WORDS-1-i)*WIDTH +: WIDTH];
            end
        end
    endfunction

    word_counter #(
        .WORDS (WORDS)
    ) u_word_counter (
        .clk        (Clock),
        .rst        (Res),
        .clr        (cnt_clr),
        .inc        (cnt_inc),
        .idx_next_c (idx_next),
        .last_c     (idx_last)
    );

    // Control: block capture, transfer stepping and end-of-block detection
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (state_q == IDLE) begin
            if (Load) begin
                buf_d   = In_block;
                cnt_clr = 1'b1;
                state_d = SEND;
            end
        end else begin
            if (Out_ready) begin
                cnt_inc = 1'b1;
                if (idx_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    // Output next values, derived from the next state so outputs come straight from flops
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == SEND);
        out_data_d  = '0;
        addr_d      = '0;
        if (state_d == SEND) begin
            out_data_d = word_sel(buf_d, idx_next);
            addr_d     = idx_next;
        end
    end

    // State, buffer and output registers
    always_ff @(posedge Clock or posedge Res) begin
        if (Res) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            addr_q      <= addr_d;
        end
    end

    assign In_ready  = in_ready_q;
    assign Out_valid = out_valid_q;
    assign Out_data  = out_data_q;
    assign Addr_out  = addr_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_block_unpacker.sv
// Directed bench for block_unpacker (WORDS=4 and WORDS=8 instances).
module tb_block_unpacker;

    logic         clk;
    logic         rst;

    logic         load4;
    logic [127:0] blk4;
    logic         in_ready4;
    logic         out_valid4;
    logic         out_ready4;
    logic [31:0]  out_data4;
    logic [2:0]   addr4;
    logic         done4;

    logic         load8;
    logic [255:0] blk8;
    logic         in_ready8;
    logic         out_valid8;
    logic         out_ready8;
    logic [31:0]  out_data8;
    logic [2:0]   addr8;
    logic         done8;

    int n_cmp;
    int n_err;

    block_unpacker #(.WIDTH(32), .WORDS(4)) dut4 (
        .Clock     (clk),
        .Res       (rst),
        .Load      (load4),
        .In_block  (blk4),
        .In_ready  (in_ready4),
        .Out_valid (out_valid4),
        .Out_ready (out_ready4),
        .Out_data  (out_data4),
        .Addr_out  (addr4),
        .Done      (done4)
    );

    block_unpacker #(.WIDTH(32), .WORDS(8)) dut8 (
        .Clock     (clk),
        .Res       (rst),
        .Load      (load8),
        .In_block  (blk8),
        .In_ready  (in_ready8),
        .Out_valid (out_valid8),
        .Out_ready (out_ready8),
        .Out_data  (out_data8),
        .Addr_out  (addr8),
        .Done      (done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the full output picture of the WORDS=4 instance
    task automatic expect4(input string tag, input logic rdy, input logic vld,
                           input logic [2:0] a, input logic [31:0] d, input logic dn);
        check({tag, ".in_ready"},  64'(in_ready4),  64'(rdy));
        check({tag, ".out_valid"}, 64'(out_valid4), 64'(vld));
        check({tag, ".addr"},      64'(addr4),      64'(a));
        check({tag, ".data"},      64'(out_data4),  64'(d));
        check({tag, ".done"},      64'(done4),      64'(dn));
    endtask

    initial begin
        logic [31:0] wa [4];
        logic [31:0] wb [4];
        int          cyc;

        wa = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        wb = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        load4 = 1'b0; blk4 = '0; out_ready4 = 1'b1;
        load8 = 1'b0; blk8 = '0; out_ready8 = 1'b1;

        // Reset then idle, with Out_ready high while nothing is valid
        tick();
        expect4("reset", 1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        expect4("idle", 1'b1, 1'b0, 3'd0, 32'h0, 1'b0);

        // Streaming block at full rate
        blk4 = 128'h11111111_22222222_33333333_44444444;
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect4($sformatf("stream.w%0d", k), 1'b0, 1'b1, 3'(k), wa[k], 1'b0);
            tick();
        end
        expect4("stream.done", 1'b1, 1'b0, 3'd0, 32'h0, 1'b1);
        tick();
        check("stream.done_width", 64'(done4), 64'd0);

        // Backpressure: three stall cycles while word 1 is presented
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        cyc = 1;
        expect4("bp.w0", 1'b0, 1'b1, 3'd0, wa[0], 1'b0);
        tick(); cyc++;
        out_ready4 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            expect4($sformatf("bp.hold%0d", s), 1'b0, 1'b1, 3'd1, wa[1], 1'b0);
            tick(); cyc++;
        end
        out_ready4 = 1'b1;
        expect4("bp.w1", 1'b0, 1'b1, 3'd1, wa[1], 1'b0);
        tick(); cyc++;
        expect4("bp.w2", 1'b0, 1'b1, 3'd2, wa[2], 1'b0);
        tick(); cyc++;
        expect4("bp.w3", 1'b0, 1'b1, 3'd3, wa[3], 1'b0);
        while (!done4 && cyc < 20) begin
            tick(); cyc++;
        end
        check("bp.cycles_to_done", 64'(cyc), 64'd8);
        tick();

        // Load while busy is ignored; Load in the Done cycle is accepted
        load4 = 1'b1;
        tick();
        blk4 = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
        for (int k = 0; k < 4; k++) begin
            expect4($sformatf("busy.w%0d", k), 1'b0, 1'b1, 3'(k), wa[k], 1'b0);
            tick();
        end
        expect4("busy.done", 1'b1, 1'b0, 3'd0, 32'h0, 1'b1);
        tick();
        load4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect4($sformatf("b2b.w%0d", k), 1'b0, 1'b1, 3'(k), wb[k], 1'b0);
            tick();
        end
        expect4("b2b.done", 1'b1, 1'b0, 3'd0, 32'h0, 1'b1);
        tick();

        // Asynchronous reset after word 2 is accepted
        blk4 = 128'h11111111_22222222_33333333_44444444;
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        tick();
        tick();
        tick();
        expect4("mid.w3", 1'b0, 1'b1, 3'd3, wa[3], 1'b0);
        rst = 1'b1;
        #1;
        expect4("mid.async_rst", 1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
        #1;
        rst = 1'b0;
        tick();
        expect4("mid.no_done", 1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
        blk4 = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        expect4("mid.restart", 1'b0, 1'b1, 3'd0, wb[0], 1'b0);
        tick();
        expect4("mid.restart_w1", 1'b0, 1'b1, 3'd1, wb[1], 1'b0);

        // Eight-word instance covers addresses 0..7
        for (int k = 0; k < 8; k++) begin
            blk8[(8-k)*32-1 -: 32] = 32'h1000_0000 + 32'(k);
        end
        load8 = 1'b1;
        tick();
        load8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("w8.valid%0d", k), 64'(out_valid8), 64'd1);
            check($sformatf("w8.addr%0d", k),  64'(addr8),      64'(k));
            check($sformatf("w8.data%0d", k),  64'(out_data8),  64'(32'h1000_0000 + 32'(k)));
            check($sformatf("w8.done%0d", k),  64'(done8),      64'd0);
            tick();
        end
        check("w8.done",     64'(done8),     64'd1);
        check("w8.in_ready", 64'(in_ready8), 64'd1);
        tick();
        check("w8.done_width", 64'(done8), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/block_unpacker.md
# block_unpacker

Streams a packed result block back out as individual words; the read-side counterpart to the word-addressed output memory that packs 32-bit words into a 128-bit block. It accepts one WORDS×WIDTH block on a load pulse and emits it word by word over a valid/ready handshake, tagging each word with its 3-bit word address. It sits between the shared hardware's packed output and the 32-bit bus or host interface that drains results.

## Interface
- WIDTH, 32, bits per word
- WORDS, 4, words per block (2..8; address is 3 bits)
- Clock  input  1  rising-edge clock
- Res  input  1  asynchronous, active-high reset
- Load  input  1  capture In_block this cycle; honoured only when In_ready=1
- In_block  input  WORDS*WIDTH  packed block; word k = In_block[(WORDS-k)*WIDTH-1 -: WIDTH], so word 0 is the MSB slice
- In_ready  output  1  block can be loaded (state IDLE)
- Out_valid  output  1  Out_data/Addr_out hold a word
- Out_ready  input  1  consumer accepts the word this cycle
- Out_data  output  WIDTH  current word
- Addr_out  output  3  index of current word, 0..WORDS-1
- Done  output  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, SEND.
- IDLE: In_ready=1, Out_valid=0. Load=1 → latch In_block into the internal buffer, word index=0, go to SEND.
- SEND: Out_valid=1, Out_data=buffer word[index], Addr_out=index, In_ready=0. Load is ignored and the buffer is not overwritten.
- Handshake: transfer occurs on a rising edge with Out_valid&Out_ready. On a transfer with index<WORDS-1, index increments. On a transfer with index=WORDS-1, go to IDLE, index→0, and Done=1 for the next cycle.
- Out_ready low: Out_data and Addr_out hold stable; no timeout.
- Out_ready may be high while Out_valid=0; this has no effect.
- Reset (any time, including mid-block): state=IDLE, index=0, buffer=0, Done=0. The partial block is discarded and no Done is issued.
- Reset values: In_ready=1, Out_valid=0, Out_data=0, Addr_out=0, Done=0.
- All outputs are registered or decoded from state/index/buffer only; there is no combinational path from Load or Out_ready to any output.

## Timing
- Load accepted at edge n → Out_valid=1 with word 0 from cycle n+1.
- With Out_ready held high, one word per cycle: words 0..3 in cycles n+1..n+4, Done=1 and In_ready=1 in cycle n+5.
- Minimum block period is WORDS+1 cycles.
- A Load in the Done cycle is accepted: back-to-back blocks with a one-cycle bubble.
- Load and the final transfer on the same edge: Load is ignored because In_ready=0 in that cycle.
- Each transfer stall (Out_ready=0) adds exactly one cycle.

## Structure
- Shared package `unpack_pkg`:
  - state enum {IDLE, SEND}
  - localparams ADDR_W=3, default WIDTH/WORDS
- Single module, no sub-module required.
- The word index counter with its last-word compare may be split out as `word_counter` if reused by the packer side.

## Test plan
- Reset then idle: Res pulse → In_ready=1, Out_valid=0, Out_data=0, Addr_out=0, Done=0.
- Streaming block: Load In_block=0x11111111_22222222_33333333_44444444 with Out_ready=1 → (addr,data) = (0,0x11111111),(1,0x22222222),(2,0x33333333),(3,0x44444444) on consecutive cycles, then Done pulse of exactly one cycle.
- Backpressure: same block, Out_ready low for 3 cycles while at word 1 → Addr_out=1 and data 0x22222222 held stable, no duplicate or skipped word, total 8 cycles from load to Done.
- Load while busy: second Load with 0xAAAA… during SEND → ignored, first block output unchanged. A Load in the Done cycle → accepted, next word 0 in the following cycle.
- Reset mid-operation: assert Res asynchronously after word 2 is accepted → outputs reset immediately without waiting for a clock edge, no Done; the next block restarts at Addr_out=0.
- Parameter check: WORDS=8 → Addr_out covers 0..7 and Done follows the 8th transfer.
